// File: rtl/vdp_pkg.sv
// Shared VDP definitions: dot-phase encodings, sprite window width and
// line-buffer entry layout used by the sprite pipeline stages.
package vdp_pkg;

    typedef enum logic [1:0] {
        DS_00 = 2'b00,
        DS_01 = 2'b01,
        DS_11 = 2'b11,
        DS_10 = 2'b10
    } dot_state_t;

    localparam logic [9:0] SP_WINDOW_WIDTH = 10'd256;
    localparam int         LB_ENTRY_W      = 8;
    localparam int         LB_COLOR_W      = 4;

    // Colour 0 is transparent: a sprite dot is present only for a non-zero code.
    function automatic logic sp_is_opaque(input logic [LB_COLOR_W-1:0] color);
        return (color != {LB_COLOR_W{1'b0}});
    endfunction

endpackage

// File: rtl/vdp_sprite_display_if.sv
// Sprite line-buffer display port: pair address, clear strobe and the
// even/odd read data returned one clock after the address.
interface vdp_sprite_display_if;
    import vdp_pkg::*;

    logic [6:0]            line_buffer_display_adr;
    logic                  line_buffer_display_we;
    logic [LB_ENTRY_W-1:0] line_buffer_xeven_q;
    logic [LB_ENTRY_W-1:0] line_buffer_xodd_q;

    modport master (
        output line_buffer_display_adr,
        output line_buffer_display_we,
        input  line_buffer_xeven_q,
        input  line_buffer_xodd_q
    );

    modport slave (
        input  line_buffer_display_adr,
        input  line_buffer_display_we,
        output line_buffer_xeven_q,
        output line_buffer_xodd_q
    );

endinterface

// File: rtl/vdp_sprite_display.sv
// Final sprite stage: reads the sprite line buffer per displayed dot, hands the
// colour to the mixer and clears each buffer pair once it has been read.
module vdp_sprite_display
    import vdp_pkg::*;
(
    input  logic                  reset,
    input  logic                  clk21m,
    input  logic [1:0]            dot_state,
    input  logic [8:0]            dot_counter_x,
    input  logic [2:0]            reg_r27_h_scroll,
    output logic                  sp_color_out,
    output logic [LB_COLOR_W-1:0] sp_color_code,
    output logic                  sp_display_en,
    vdp_sprite_display_if.master  lb
);

    logic [8:0]            x_pix_s;
    logic                  x_in_window_s;
    logic [LB_ENTRY_W-1:0] entry_sel_s;
    logic [LB_COLOR_W-1:0] color_sel_s;
    logic                  entry_unused_s;

    logic [6:0]            adr_r;
    logic                  sel_r;
    logic                  win_r;
    logic                  we_r;
    logic [LB_COLOR_W-1:0] code_r;
    logic                  out_r;
    logic                  en_r;

    logic [6:0]            adr_s;
    logic                  sel_s;
    logic                  win_s;
    logic                  we_s;
    logic [LB_COLOR_W-1:0] code_s;
    logic                  out_s;
    logic                  en_s;

    // Scroll shifts the sprite plane right; the 9-bit wrap puts the first dots above 255.
    assign x_pix_s        = dot_counter_x - {6'd0, reg_r27_h_scroll};
    assign x_in_window_s  = ({1'b0, x_pix_s} < SP_WINDOW_WIDTH);
    assign entry_sel_s    = sel_r ? lb.line_buffer_xodd_q : lb.line_buffer_xeven_q;
    assign color_sel_s    = entry_sel_s[LB_COLOR_W-1:0];
    assign entry_unused_s = ^entry_sel_s[LB_ENTRY_W-1:LB_COLOR_W];

    // Next-state selection driven by the dot phase.
    always_comb begin
        adr_s  = adr_r;
        sel_s  = sel_r;
        win_s  = win_r;
        we_s   = 1'b0;
        code_s = code_r;
        out_s  = out_r;
        en_s   = en_r;
        case (dot_state)
            DS_10: begin
                adr_s = x_pix_s[7:1];
                sel_s = x_pix_s[0];
                win_s = x_in_window_s;
            end
            DS_00: begin
                if (win_r) begin
                    code_s = color_sel_s;
                    out_s  = sp_is_opaque(color_sel_s);
                    en_s   = 1'b1;
                end else begin
                    code_s = {LB_COLOR_W{1'b0}};
                    out_s  = 1'b0;
                    en_s   = 1'b0;
                end
            end
            DS_01: begin
                // The odd dot closes a pair; its read already happened in phase 00.
                we_s = win_r & sel_r;
            end
            DS_11: begin
                we_s = 1'b0;
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Pipeline and output registers.
    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            adr_r  <= 7'd0;
            sel_r  <= 1'b0;
            win_r  <= 1'b0;
            we_r   <= 1'b0;
            code_r <= {LB_COLOR_W{1'b0}};
            out_r  <= 1'b0;
            en_r   <= 1'b0;
        end else begin
            adr_r  <= adr_s;
            sel_r  <= sel_s;
            win_r  <= win_s;
            we_r   <= we_s;
            code_r <= code_s;
            out_r  <= out_s;
            en_r   <= en_s;
        end
    end

    assign lb.line_buffer_display_adr = adr_r;
    assign lb.line_buffer_display_we  = we_r;
    assign sp_color_code              = code_r;
    assign sp_color_out               = out_r;
    assign sp_display_en              = en_r;

endmodule

// File: tb/tb_vdp_sprite_display.sv
// Self-checking bench for vdp_sprite_display: a line-buffer memory model plus a
// per-dot reference of the expected sprite output, pair address and clear strobe.
module tb_vdp_sprite_display;

    logic       clk21m = 1'b0;
    logic       reset;
    logic [1:0] dot_state;
    logic [8:0] dot_counter_x;
    logic [2:0] reg_r27_h_scroll;
    logic       sp_color_out;
    logic [3:0] sp_color_code;
    logic       sp_display_en;

    vdp_sprite_display_if lb();

    vdp_sprite_display dut (
        .reset            (reset),
        .clk21m           (clk21m),
        .dot_state        (dot_state),
        .dot_counter_x    (dot_counter_x),
        .reg_r27_h_scroll (reg_r27_h_scroll),
        .sp_color_out     (sp_color_out),
        .sp_color_code    (sp_color_code),
        .sp_display_en    (sp_display_en),
        .lb               (lb)
    );

    always #23 clk21m = ~clk21m;

    // Line-buffer model: data addressed by the registered pair address, cleared on we.
    logic [7:0] even_mem [128];
    logic [7:0] odd_mem  [128];
    logic [7:0] new_even [128];
    logic [7:0] new_odd  [128];
    logic       fill_req;

    assign lb.line_buffer_xeven_q = even_mem[lb.line_buffer_display_adr];
    assign lb.line_buffer_xodd_q  = odd_mem[lb.line_buffer_display_adr];

    always @(posedge clk21m) begin
        if (fill_req) begin
            for (int i = 0; i < 128; i++) begin
                even_mem[i] <= new_even[i];
                odd_mem[i]  <= new_odd[i];
            end
        end else if (lb.line_buffer_display_we) begin
            even_mem[lb.line_buffer_display_adr] <= 8'h00;
            odd_mem[lb.line_buffer_display_adr]  <= 8'h00;
        end
    end

    int checks = 0;
    int fails  = 0;

    // Reference state: what the outputs must show, held since the last update.
    logic [7:0] snap [256];
    logic [3:0] exp_code;
    logic       exp_out;
    logic       exp_en;
    logic       exp_we_pend;
    logic [6:0] exp_adr;
    logic [6:0] we_q [$];

    task automatic model_clear();
        exp_code = 4'd0; exp_out = 1'b0; exp_en = 1'b0;
        exp_we_pend = 1'b0; exp_adr = 7'd0;
    endtask

    task automatic load_line(input bit pattern);
        logic [7:0] e;
        for (int p = 0; p < 128; p++) begin
            if (pattern) begin
                new_even[p] = {4'h0, p[2:0], 1'b0};
                new_odd[p]  = {4'h0, p[2:0], 1'b1};
            end else begin
                e = 8'($urandom);
                if ($urandom_range(0, 3) == 0) e[3:0] = 4'h0;
                new_even[p] = e;
                e = 8'($urandom);
                if ($urandom_range(0, 3) == 0) e[3:0] = 4'h0;
                new_odd[p] = e;
            end
            snap[2*p]   = new_even[p];
            snap[2*p+1] = new_odd[p];
        end
    endtask

    // One dot: phases 11,10,00,01 with the outputs checked in every clock.
    task automatic run_dot(input logic [8:0] x, input logic [2:0] hs, input bit first);
        logic [8:0]  xp;
        logic        win;
        logic [7:0]  ent;
        logic [1:0]  ds;
        logic [13:0] obs;
        logic [13:0] expv;
        logic        we_exp;
        xp  = x - {6'd0, hs};
        win = (xp < 9'd256);
        reg_r27_h_scroll = hs;
        for (int ph = 0; ph < 4; ph++) begin
            we_exp = 1'b0;
            case (ph)
                0: begin ds = 2'b11; we_exp = exp_we_pend; end
                1: ds = 2'b10;
                2: begin ds = 2'b00; exp_adr = xp[7:1]; end
                default: begin
                    ds = 2'b01;
                    ent = win ? snap[xp[7:0]] : 8'h00;
                    exp_en = win;
                    exp_code = ent[3:0];
                    exp_out = (ent[3:0] != 4'h0);
                    exp_we_pend = win & xp[0];
                end
            endcase
            @(posedge clk21m);
            #1;
            dot_state = ds;
            dot_counter_x = x;
            fill_req = first && (ph == 0);
            @(negedge clk21m);
            obs  = {sp_display_en, sp_color_out, sp_color_code,
                    lb.line_buffer_display_we, lb.line_buffer_display_adr};
            expv = {exp_en, exp_out, exp_code, we_exp, exp_adr};
            checks++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL dot x=%0d hs=%0d phase=%b: {en,out,code,we,adr} got %h expected %h",
                         x, hs, ds, obs, expv);
            end
            if (lb.line_buffer_display_we === 1'b1) we_q.push_back(lb.line_buffer_display_adr);
        end
        fill_req = 1'b0;
    endtask

    // Whole line 511,0..341, then the clear sequence and buffer contents are checked.
    task automatic run_line(input logic [2:0] hs, input bit pattern);
        bit ok;
        int nz;
        load_line(pattern);
        we_q.delete();
        run_dot(9'd511, hs, 1'b1);
        for (int x = 0; x <= 341; x++) run_dot(9'(x), hs, 1'b0);
        ok = (we_q.size() == 128);
        for (int i = 0; i < we_q.size() && ok; i++) if (we_q[i] != 7'(i)) ok = 1'b0;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL clear_sequence hs=%0d: got %0d pulses (order ok=%0d) expected 128 in order 0..127",
                     hs, we_q.size(), ok);
        end
        nz = 0;
        for (int p = 0; p < 128; p++) if (even_mem[p] != 8'h00 || odd_mem[p] != 8'h00) nz++;
        checks++;
        if (nz != 0) begin
            fails++;
            $display("FAIL buffer_empty hs=%0d: %0d pairs not cleared, expected 0", hs, nz);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dot_state = 2'b01;
        dot_counter_x = 9'd341;
        reg_r27_h_scroll = 3'd0;
        fill_req = 1'b0;
        repeat (3) @(posedge clk21m);
        @(negedge clk21m);
        checks++;
        if ({sp_display_en, sp_color_out, sp_color_code, lb.line_buffer_display_we,
             lb.line_buffer_display_adr} !== 14'd0) begin
            fails++;
            $display("FAIL reset_state: en=%b out=%b code=%h we=%b adr=%h expected all 0",
                     sp_display_en, sp_color_out, sp_color_code,
                     lb.line_buffer_display_we, lb.line_buffer_display_adr);
        end
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_pattern();
        run_line(3'd0, 1'b1);
    endtask

    task automatic test_hscroll3();
        run_line(3'd3, 1'b1);
    endtask

    task automatic test_random_lines();
        for (int l = 0; l < 4; l++) run_line(3'($urandom_range(0, 7)), 1'b0);
    endtask

    task automatic test_reset_mid_line();
        load_line(1'b0);
        run_dot(9'd511, 3'd0, 1'b1);
        for (int x = 0; x < 100; x++) run_dot(9'(x), 3'd0, 1'b0);
        @(posedge clk21m); #1; dot_state = 2'b11; dot_counter_x = 9'd100;
        @(posedge clk21m); #1; dot_state = 2'b10;
        #5 reset = 1'b1;
        #1;
        checks++;
        if ({sp_display_en, sp_color_out, sp_color_code, lb.line_buffer_display_we,
             lb.line_buffer_display_adr} !== 14'd0) begin
            fails++;
            $display("FAIL reset_mid_line: en=%b out=%b code=%h we=%b adr=%h expected all 0",
                     sp_display_en, sp_color_out, sp_color_code,
                     lb.line_buffer_display_we, lb.line_buffer_display_adr);
        end
        @(posedge clk21m); #1; dot_state = 2'b00;
        @(posedge clk21m); #1; dot_state = 2'b01;
        @(negedge clk21m);
        reset = 1'b0;
        model_clear();
        for (int x = 101; x <= 341; x++) run_dot(9'(x), 3'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_line(3'd7, 1'b0);
        run_line(3'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_hscroll3();
        test_random_lines();
        test_reset_mid_line();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
